seg7_bcd_capture: RTL and testbench

//  Inverse of the BCD->7-segment decoder. Snoops a multiplexed 7-segment bus (segments plus digit enables).

---
 rtl/seg7_bcd_capture_if.sv | 35 +++
 rtl/seg7_bcd_capture.sv | 174 +++++++++++++++++
 tb/tb_seg7_bcd_capture.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_capture_if.sv
// Bus between a multiplexed 7-segment display driver and the capture block.
// Optional decimal-point lines exist only when SEG7_CAP_DP_EN is defined.
interface seg7_bcd_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    capture_en;
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;
    logic [1:0]              dbg_state;
`ifdef SEG7_CAP_DP_EN
    logic                    dp_in;
    logic [NUM_DIGITS-1:0]   dp_out;

    modport master (
        output capture_en, seg_in, an_in, dp_in,
        input  bcd_out, digit_err, frame_valid, dbg_state, dp_out
    );
    modport slave (
        input  capture_en, seg_in, an_in, dp_in,
        output bcd_out, digit_err, frame_valid, dbg_state, dp_out
    );
`else
    modport master (
        output capture_en, seg_in, an_in,
        input  bcd_out, digit_err, frame_valid, dbg_state
    );
    modport slave (
        input  capture_en, seg_in, an_in,
        output bcd_out, digit_err, frame_valid, dbg_state
    );
`endif
endinterface

// File: rtl/seg7_bcd_capture.sv
// Snoops a multiplexed 7-segment bus and decodes each stable digit back to a hex code.
// Define SEG7_CAP_DP_EN to also capture the decimal point per digit.
module seg7_bcd_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    seg7_bcd_capture_if.slave bus
);
`ifdef SEG7_CAP_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int S_W = NUM_DIGITS + SEG_W;
    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_COUNT = 2'd1, ST_HELD = 2'd2} state_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    // Returns {recognised, code}; anything but an exact table match is unrecognised.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b1111110: return 5'h10;
            7'b0110000: return 5'h11;
            7'b1101101: return 5'h12;
            7'b1111001: return 5'h13;
            7'b0110011: return 5'h14;
            7'b1011011: return 5'h15;
            7'b1011111: return 5'h16;
            7'b1110000: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1111011: return 5'h19;
            7'b1110111: return 5'h1A;
            7'b0011111: return 5'h1B;
            7'b1001110: return 5'h1C;
            7'b0111101: return 5'h1D;
            7'b1001111: return 5'h1E;
            7'b1000111: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    logic [SEG_W-1:0]        w_seg_raw;
    logic [SEG_W-1:0]        r_seg_m, r_seg_s;
    logic [NUM_DIGITS-1:0]   r_an_m, r_an_s;
    logic [SEG_W-1:0]        w_seg_norm;
    logic [NUM_DIGITS-1:0]   w_an_norm;
    logic [S_W-1:0]          w_s, r_s;
    logic [NUM_DIGITS-1:0]   w_an_held;
    logic [4:0]              w_dec;
    logic                    w_changed, w_new_valid, w_accept;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    state_t                  r_state, w_state_nx;
    logic [7:0]              r_cnt, w_cnt_nx;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_err, r_seen;
    logic                    r_fv;

`ifdef SEG7_CAP_DP_EN
    logic [NUM_DIGITS-1:0]   r_dp;
    assign w_seg_raw  = {bus.dp_in, bus.seg_in};
    assign bus.dp_out = r_dp;
`else
    assign w_seg_raw  = bus.seg_in;
`endif

    // Two-flop synchroniser for the asynchronous display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m <= '0;
            r_seg_s <= '0;
            r_an_m  <= '0;
            r_an_s  <= '0;
            r_s     <= '0;
        end else begin
            r_seg_m <= w_seg_raw;
            r_seg_s <= r_seg_m;
            r_an_m  <= bus.an_in;
            r_an_s  <= r_an_m;
            r_s     <= w_s;
        end
    end

    assign w_seg_norm  = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s : r_seg_s;
    assign w_an_norm   = (AN_ACTIVE_LOW != 0) ? ~r_an_s : r_an_s;
    assign w_s         = {w_an_norm, w_seg_norm};
    assign w_an_held   = r_s[S_W-1 -: NUM_DIGITS];
    assign w_dec       = decode_seg(r_s[6:0]);
    assign w_changed   = (w_s != r_s);
    assign w_new_valid = is_onehot(w_an_norm);
    assign w_seen_next = r_seen | w_an_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // r_cnt counts consecutive identical samples of r_s; accept fires once per stable period.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = bus.capture_en && (r_state == ST_COUNT) && (r_cnt == STABLE_W);
        if (!bus.capture_en) begin
            w_state_nx = ST_WAIT;
            w_cnt_nx   = '0;
        end else if (w_changed) begin
            w_cnt_nx   = 8'd1;
            w_state_nx = w_new_valid ? ST_COUNT : ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_new_valid) begin
                        w_state_nx = ST_COUNT;
                        w_cnt_nx   = 8'd1;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) w_state_nx = ST_HELD;
                    else          w_cnt_nx   = r_cnt + 8'd1;
                end
                ST_HELD: w_state_nx = ST_HELD;
                default: w_state_nx = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd  <= '0;
            r_err  <= '0;
            r_seen <= '0;
            r_fv   <= 1'b0;
`ifdef SEG7_CAP_DP_EN
            r_dp   <= '0;
`endif
        end else begin
            r_fv <= 1'b0;
            if (w_accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_an_held[i]) begin
                        if (w_dec[4]) r_bcd[4*i +: 4] <= w_dec[3:0];
                        r_err[i] <= ~w_dec[4];
`ifdef SEG7_CAP_DP_EN
                        r_dp[i]  <= r_s[7];
`endif
                    end
                end
                if (&w_seen_next) begin
                    r_fv   <= 1'b1;
                    r_seen <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end
        end
    end

    assign bus.bcd_out     = r_bcd;
    assign bus.digit_err   = r_err;
    assign bus.frame_valid = r_fv;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Directed bench for seg7_bcd_capture (NUM_DIGITS=4, STABLE_CYCLES=4, active-low enables).
// Decimal-point checks are compiled in when SEG7_CAP_DP_EN is defined.
module tb_seg7_bcd_capture;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   fv_count = 0;
    logic [15:0] fv_bcd = '0;
`ifdef SEG7_CAP_DP_EN
    logic [3:0] dp_plan = 4'b0000;
`endif

    seg7_bcd_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_bcd_capture #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_count++;
            fv_bcd = bus.bcd_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    task automatic blank(input int n);
        bus.an_in = 4'b1111;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int n);
        bus.an_in  = ~(ND'(1) << idx);
        bus.seg_in = pat;
`ifdef SEG7_CAP_DP_EN
        bus.dp_in  = dp_plan[idx];
`endif
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.bcd_out !== 16'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", bus.bcd_out); end
        n_tests++; if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %b want 0000", bus.digit_err); end
        n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", bus.frame_valid); end
        n_tests++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency;
        bus.an_in  = 4'b1110;
        bus.seg_in = 7'b0110000;
        repeat (6) @(negedge clk);
        n_tests++; if (bus.bcd_out[3:0] !== 4'h0) begin n_fail++; $display("FAIL latency_early: got %h want 0", bus.bcd_out[3:0]); end
        @(negedge clk);
        n_tests++; if (bus.bcd_out[3:0] !== 4'h1) begin n_fail++; $display("FAIL latency_7clk: got %h want 1", bus.bcd_out[3:0]); end
        repeat (3) @(negedge clk);
        blank(2);
        #1;
        n_tests++; if (fv_count !== 0) begin n_fail++; $display("FAIL latency_no_fv: got %0d pulses want 0", fv_count); end
    endtask

    task automatic test_scan;
        logic [3:0] codes [4] = '{4'h3, 4'hA, 4'h7, 4'hF};
        int fv0 = fv_count;
        for (int i = 0; i < 4; i++) begin
            show(i, seg_of(codes[i]), 10);
            blank(2);
        end
        #1;
        n_tests++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL scan_fv_count: got %0d want 1", fv_count - fv0); end
        n_tests++; if (fv_bcd !== 16'hF7A3) begin n_fail++; $display("FAIL scan_fv_bcd: got %h want F7A3", fv_bcd); end
        n_tests++; if (bus.bcd_out !== 16'hF7A3) begin n_fail++; $display("FAIL scan_bcd: got %h want F7A3", bus.bcd_out); end
        n_tests++; if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL scan_err: got %b want 0000", bus.digit_err); end
    endtask

    task automatic test_glitch;
        logic early_ok = 1'b1;
        show(2, seg_of(4'h6), 2);
        if (bus.bcd_out[11:8] !== 4'h7) early_ok = 1'b0;
        bus.seg_in = 7'h7F;
        repeat (2) begin @(negedge clk); if (bus.bcd_out[11:8] !== 4'h7) early_ok = 1'b0; end
        bus.seg_in = seg_of(4'h6);
        repeat (6) begin @(negedge clk); if (bus.bcd_out[11:8] !== 4'h7) early_ok = 1'b0; end
        n_tests++; if (early_ok !== 1'b1) begin n_fail++; $display("FAIL glitch_no_accept: field changed early, now %h want 7", bus.bcd_out[11:8]); end
        @(negedge clk);
        n_tests++; if (bus.bcd_out[11:8] !== 4'h6) begin n_fail++; $display("FAIL glitch_accept: got %h want 6", bus.bcd_out[11:8]); end
        repeat (3) @(negedge clk);
        blank(2);
    endtask

    task automatic test_error;
        show(1, 7'b1010101, 10);
        blank(2);
        n_tests++; if (bus.digit_err !== 4'b0010) begin n_fail++; $display("FAIL err_set: got %b want 0010", bus.digit_err); end
        n_tests++; if (bus.bcd_out !== 16'hF6A3) begin n_fail++; $display("FAIL err_hold: got %h want F6A3", bus.bcd_out); end
        show(1, seg_of(4'h5), 10);
        blank(2);
        n_tests++; if (bus.digit_err !== 4'b0000) begin n_fail++; $display("FAIL err_clear: got %b want 0000", bus.digit_err); end
        n_tests++; if (bus.bcd_out !== 16'hF653) begin n_fail++; $display("FAIL err_recover: got %h want F653", bus.bcd_out); end
    endtask

    task automatic test_disable;
        logic [3:0] codes [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        int fv0 = fv_count;
        bus.an_in  = 4'b1100;
        bus.seg_in = seg_of(4'h1);
        repeat (20) @(negedge clk);
        blank(2);
        n_tests++; if (bus.bcd_out !== 16'hF653) begin n_fail++; $display("FAIL multi_en_bcd: got %h want F653", bus.bcd_out); end
        bus.capture_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            show(i, seg_of(codes[i]), 10);
            blank(2);
        end
        #1;
        n_tests++; if (bus.bcd_out !== 16'hF653) begin n_fail++; $display("FAIL disabled_bcd: got %h want F653", bus.bcd_out); end
        n_tests++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL disabled_fv: got %0d pulses want 0", fv_count - fv0); end
        show(0, seg_of(4'h9), 4);
        bus.capture_en = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.bcd_out[3:0] !== 4'h3) begin n_fail++; $display("FAIL reenable_early: got %h want 3", bus.bcd_out[3:0]); end
        @(negedge clk);
        n_tests++; if (bus.bcd_out[3:0] !== 4'h9) begin n_fail++; $display("FAIL reenable_accept: got %h want 9", bus.bcd_out[3:0]); end
        repeat (3) @(negedge clk);
        blank(2);
        #1;
        n_tests++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL reenable_fv: got %0d pulses want 0", fv_count - fv0); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] codes1 [3] = '{4'h1, 4'h2, 4'h4};
        logic [3:0] codes2 [3] = '{4'hC, 4'hD, 4'hE};
        int fv0 = fv_count;
        for (int i = 0; i < 3; i++) begin
            show(i, seg_of(codes1[i]), 10);
            blank(2);
        end
        n_tests++; if (bus.bcd_out !== 16'hF421) begin n_fail++; $display("FAIL pre_reset_bcd: got %h want F421", bus.bcd_out); end
        show(3, seg_of(4'h8), 4);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.bcd_out !== 16'h0) begin n_fail++; $display("FAIL midreset_bcd: got %h want 0000", bus.bcd_out); end
        n_tests++; if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL midreset_err: got %b want 0000", bus.digit_err); end
        blank(3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL midreset_fv: got %0d pulses want 0", fv_count - fv0); end
`ifdef SEG7_CAP_DP_EN
        n_tests++; if (bus.dp_out !== 4'b0000) begin n_fail++; $display("FAIL midreset_dp: got %b want 0000", bus.dp_out); end
        dp_plan = 4'b1101;
`endif
        for (int i = 0; i < 3; i++) begin
            show(i, seg_of(codes2[i]), 10);
            blank(2);
        end
        #1;
        n_tests++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL rescan_partial_fv: got %0d pulses want 0", fv_count - fv0); end
        n_tests++; if (bus.bcd_out !== 16'h0EDC) begin n_fail++; $display("FAIL rescan_partial_bcd: got %h want 0EDC", bus.bcd_out); end
        show(3, seg_of(4'hB), 10);
        blank(2);
        #1;
        n_tests++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL rescan_fv: got %0d pulses want 1", fv_count - fv0); end
        n_tests++; if (fv_bcd !== 16'hBEDC) begin n_fail++; $display("FAIL rescan_fv_bcd: got %h want BEDC", fv_bcd); end
        n_tests++; if (bus.bcd_out !== 16'hBEDC) begin n_fail++; $display("FAIL rescan_bcd: got %h want BEDC", bus.bcd_out); end
`ifdef SEG7_CAP_DP_EN
        n_tests++; if (bus.dp_out !== 4'b1101) begin n_fail++; $display("FAIL rescan_dp: got %b want 1101", bus.dp_out); end
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.capture_en = 1'b1;
        bus.an_in      = 4'b1111;
        bus.seg_in     = 7'h00;
`ifdef SEG7_CAP_DP_EN
        bus.dp_in      = 1'b0;
`endif
        test_reset;
        test_latency;
        test_scan;
        test_glitch;
        test_error;
        test_disable;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
